// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32I decode stage and the execute-stage ALU:
//   - alu_op_t  : 4-bit ALU control code type
//   - ALU_*     : fixed ALU control codes
//   - OPC_*     : RV32I major opcodes handled by the decoder
//   - F7_*      : funct7 patterns that select base / alternate ALU ops
//   - ex_fields_t : bundle of every field held in the ID/EX register
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SUB = 4'b0110;
  localparam alu_op_t ALU_SLL = 4'b0001;
  localparam alu_op_t ALU_SRL = 4'b0101;
  localparam alu_op_t ALU_SRA = 4'b0100;
  localparam alu_op_t ALU_XOR = 4'b0000;
  localparam alu_op_t ALU_AND = 4'b0011;
  localparam alu_op_t ALU_OR  = 4'b1000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_t     alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] store_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        branch_ne;
    logic        illegal;
  } ex_fields_t;

endpackage

// File: rtl/alu_dec_comb.sv
// -----------------------------------------------------------------------------
// alu_dec_comb
// Purely combinational RV32I decode of one instruction into the fields that
// the ID/EX register captures.
//   instr      in  32  instruction word
//   pc         in  32  instruction address (AUIPC / JAL / JALR operand a)
//   rs1_data   in  32  forwarded rs1 value
//   rs2_data   in  32  forwarded rs2 value
//   fields     out     decoded ALU code, operands, immediate, rd and controls;
//                      fields.illegal marks encodings the ALU cannot execute,
//                      and such encodings carry ADD with every side effect off
// -----------------------------------------------------------------------------
module alu_dec_comb
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output ex_fields_t  fields
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] shamt_rs2, shamt_imm;
  logic        writes_rd;
  logic        illegal;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Shift amounts are only the low five bits; upper operand bits must not leak.
  assign shamt_rs2 = {27'b0, rs2_data[4:0]};
  assign shamt_imm = {27'b0, instr[24:20]};

  always_comb begin
    fields            = '0;
    illegal           = 1'b0;
    writes_rd         = 1'b0;
    fields.alucontrol = ALU_ADD;
    fields.a          = rs1_data;
    fields.b          = rs2_data;
    fields.store_data = rs2_data;
    fields.rd         = rd;

    case (opcode)
      OPC_OP: begin
        writes_rd = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: fields.alucontrol = ALU_ADD;
          {F7_BASE, 3'b001}: begin fields.alucontrol = ALU_SLL; fields.b = shamt_rs2; end
          {F7_BASE, 3'b100}: fields.alucontrol = ALU_XOR;
          {F7_BASE, 3'b101}: begin fields.alucontrol = ALU_SRL; fields.b = shamt_rs2; end
          {F7_BASE, 3'b110}: fields.alucontrol = ALU_OR;
          {F7_BASE, 3'b111}: fields.alucontrol = ALU_AND;
          {F7_ALT,  3'b000}: fields.alucontrol = ALU_SUB;
          {F7_ALT,  3'b101}: begin fields.alucontrol = ALU_SRA; fields.b = shamt_rs2; end
          default:           illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        writes_rd  = 1'b1;
        fields.b   = imm_i;
        fields.imm = imm_i;
        case (funct3)
          3'b000: fields.alucontrol = ALU_ADD;
          3'b100: fields.alucontrol = ALU_XOR;
          3'b110: fields.alucontrol = ALU_OR;
          3'b111: fields.alucontrol = ALU_AND;
          3'b001: begin
            fields.alucontrol = ALU_SLL;
            fields.b          = shamt_imm;
            if (funct7 != F7_BASE) illegal = 1'b1;
          end
          3'b101: begin
            fields.b = shamt_imm;
            if (funct7 == F7_BASE)     fields.alucontrol = ALU_SRL;
            else if (funct7 == F7_ALT) fields.alucontrol = ALU_SRA;
            else                       illegal = 1'b1;
          end
          default: illegal = 1'b1;  // SLTI / SLTIU
        endcase
      end
      OPC_LOAD: begin
        writes_rd      = 1'b1;
        fields.b       = imm_i;
        fields.imm     = imm_i;
        fields.memread = 1'b1;
      end
      OPC_STORE: begin
        fields.b        = imm_s;
        fields.imm      = imm_s;
        fields.memwrite = 1'b1;
      end
      OPC_BRANCH: begin
        // Only equality compares are possible on a SUB-only comparator.
        fields.alucontrol = ALU_SUB;
        fields.imm        = imm_b;
        fields.branch     = 1'b1;
        case (funct3)
          3'b000:  fields.branch_ne = 1'b0;
          3'b001:  fields.branch_ne = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        writes_rd  = 1'b1;
        fields.a   = 32'd0;
        fields.b   = imm_u;
        fields.imm = imm_u;
      end
      OPC_AUIPC: begin
        writes_rd  = 1'b1;
        fields.a   = pc;
        fields.b   = imm_u;
        fields.imm = imm_u;
      end
      OPC_JAL: begin
        // ALU computes the link address; the target adder uses ex_imm.
        writes_rd  = 1'b1;
        fields.a   = pc;
        fields.b   = 32'd4;
        fields.imm = imm_j;
      end
      OPC_JALR: begin
        writes_rd  = 1'b1;
        fields.a   = pc;
        fields.b   = 32'd4;
        fields.imm = imm_i;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      fields.alucontrol = ALU_ADD;
      fields.memread    = 1'b0;
      fields.memwrite   = 1'b0;
      fields.branch     = 1'b0;
      fields.branch_ne  = 1'b0;
      writes_rd         = 1'b0;
    end

    fields.regwrite = writes_rd && (rd != 5'd0);
    fields.illegal  = illegal;
  end

endmodule

// File: rtl/id_ex_alu_decode.sv
// -----------------------------------------------------------------------------
// id_ex_alu_decode
// ID/EX pipeline register of the RV32I core with valid/ready handshake and
// flush. Decode is done by alu_dec_comb; this module holds the result.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready is combinational)
//   instr, pc             instruction word and address
//   rs1_data, rs2_data    forwarded operands
//   flush                 kill held and incoming instruction
//   out_valid / out_ready downstream handshake
//   ex_*                  registered ALU code, operands, immediate, rd, controls
// Build option: ALUDEC_ILLEGAL_TRAP_EN
//   defined   - illegal instructions load as valid ops with ex_illegal=1
//   undefined - illegal instructions are accepted and become bubbles, so
//               ex_illegal never rises
// -----------------------------------------------------------------------------
module id_ex_alu_decode
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  ex_alucontrol,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_store_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_branch,
  output logic        ex_branch_ne,
  output logic        ex_illegal
);

  ex_fields_t dec_fields;
  ex_fields_t ex_reg;
  logic       out_valid_reg;
  logic       accept;
  logic       load_op;

  alu_dec_comb u_dec (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .fields   (dec_fields)
  );

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef ALUDEC_ILLEGAL_TRAP_EN
  assign load_op = 1'b1;
`else
  assign load_op = !dec_fields.illegal;
`endif

  // Empty slots are always zeroed so control fields read 0 during bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      ex_reg        <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      ex_reg        <= '0;
    end else if (accept && load_op) begin
      out_valid_reg <= 1'b1;
      ex_reg        <= dec_fields;
    end else if (accept || out_ready) begin
      out_valid_reg <= 1'b0;
      ex_reg        <= '0;
    end
  end

  assign out_valid     = out_valid_reg;
  assign ex_alucontrol = ex_reg.alucontrol;
  assign ex_a          = ex_reg.a;
  assign ex_b          = ex_reg.b;
  assign ex_store_data = ex_reg.store_data;
  assign ex_imm        = ex_reg.imm;
  assign ex_rd         = ex_reg.rd;
  assign ex_regwrite   = ex_reg.regwrite;
  assign ex_memread    = ex_reg.memread;
  assign ex_memwrite   = ex_reg.memwrite;
  assign ex_branch     = ex_reg.branch;
  assign ex_branch_ne  = ex_reg.branch_ne;
  // Without the trap option an illegal op never loads, so this bit stays 0.
  assign ex_illegal    = ex_reg.illegal;

endmodule

// File: tb/tb_id_ex_alu_decode.sv
// -----------------------------------------------------------------------------
// tb_id_ex_alu_decode
// Directed bench for id_ex_alu_decode with a mnemonic-level reference model
// and a per-cycle output comparison. Works with or without
// ALUDEC_ILLEGAL_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_id_ex_alu_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  ex_alucontrol;
  logic [31:0] ex_a, ex_b, ex_store_data, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_branch_ne, ex_illegal;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

`ifdef ALUDEC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  id_ex_alu_decode dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ex_alucontrol(ex_alucontrol), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] a, b, sd, imm;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, bne, ill;
  } exp_t;

  typedef enum int {
    M_ILL, M_ADD, M_SUB, M_SLL, M_SRL, M_SRA, M_XOR, M_OR, M_AND,
    M_ADDI, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
    M_LOAD, M_STORE, M_BEQ, M_BNE, M_LUI, M_AUIPC, M_JAL, M_JALR
  } mn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Name the instruction as an assembler would.
  function automatic mn_t mnemonic(input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      7'h33: begin
        if (f7 == 7'd0) begin
          case (f3)
            3'd0: return M_ADD;
            3'd1: return M_SLL;
            3'd4: return M_XOR;
            3'd5: return M_SRL;
            3'd6: return M_OR;
            3'd7: return M_AND;
            default: return M_ILL;
          endcase
        end
        if (f7 == 7'd32 && f3 == 3'd0) return M_SUB;
        if (f7 == 7'd32 && f3 == 3'd5) return M_SRA;
        return M_ILL;
      end
      7'h13: begin
        case (f3)
          3'd0: return M_ADDI;
          3'd4: return M_XORI;
          3'd6: return M_ORI;
          3'd7: return M_ANDI;
          3'd1: return (f7 == 7'd0) ? M_SLLI : M_ILL;
          3'd5: return (f7 == 7'd0) ? M_SRLI : ((f7 == 7'd32) ? M_SRAI : M_ILL);
          default: return M_ILL;
        endcase
      end
      7'h03: return M_LOAD;
      7'h23: return M_STORE;
      7'h63: return (f3 == 3'd0) ? M_BEQ : ((f3 == 3'd1) ? M_BNE : M_ILL);
      7'h37: return M_LUI;
      7'h17: return M_AUIPC;
      7'h6F: return M_JAL;
      7'h67: return M_JALR;
      default: return M_ILL;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, pcv, r1, r2);
    exp_t e;
    mn_t  m;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic        wr;
    i_imm = $signed(ins) >>> 20;
    s_imm = {i_imm[31:5], ins[11:7]};
    b_imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    u_imm = ins & 32'hFFFF_F000;
    j_imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    m  = mnemonic(ins);
    e  = '0;
    e.rd = ins[11:7];
    e.sd = r2;
    e.a  = r1;
    e.b  = r2;
    e.alu = 4'b0010;
    wr = 1'b1;
    case (m)
      M_ADD:   ;
      M_SUB:   e.alu = 4'b0110;
      M_XOR:   e.alu = 4'b0000;
      M_OR:    e.alu = 4'b1000;
      M_AND:   e.alu = 4'b0011;
      M_SLL:   begin e.alu = 4'b0001; e.b = r2 % 32; end
      M_SRL:   begin e.alu = 4'b0101; e.b = r2 % 32; end
      M_SRA:   begin e.alu = 4'b0100; e.b = r2 % 32; end
      M_ADDI:  begin e.b = i_imm; e.imm = i_imm; end
      M_XORI:  begin e.alu = 4'b0000; e.b = i_imm; e.imm = i_imm; end
      M_ORI:   begin e.alu = 4'b1000; e.b = i_imm; e.imm = i_imm; end
      M_ANDI:  begin e.alu = 4'b0011; e.b = i_imm; e.imm = i_imm; end
      M_SLLI:  begin e.alu = 4'b0001; e.b = ins[24:20]; e.imm = i_imm; end
      M_SRLI:  begin e.alu = 4'b0101; e.b = ins[24:20]; e.imm = i_imm; end
      M_SRAI:  begin e.alu = 4'b0100; e.b = ins[24:20]; e.imm = i_imm; end
      M_LOAD:  begin e.b = i_imm; e.imm = i_imm; e.mr = 1'b1; end
      M_STORE: begin e.b = s_imm; e.imm = s_imm; e.mw = 1'b1; wr = 1'b0; end
      M_BEQ:   begin e.alu = 4'b0110; e.imm = b_imm; e.br = 1'b1; wr = 1'b0; end
      M_BNE:   begin e.alu = 4'b0110; e.imm = b_imm; e.br = 1'b1; e.bne = 1'b1; wr = 1'b0; end
      M_LUI:   begin e.a = 0; e.b = u_imm; e.imm = u_imm; end
      M_AUIPC: begin e.a = pcv; e.b = u_imm; e.imm = u_imm; end
      M_JAL:   begin e.a = pcv; e.b = 4; e.imm = j_imm; end
      M_JALR:  begin e.a = pcv; e.b = 4; e.imm = i_imm; end
      default: begin e.ill = 1'b1; wr = 1'b0; end
    endcase
    e.rw = wr && (e.rd != 0);
    return e;
  endfunction

  // Expected content of the ID/EX register, advanced on each clock edge.
  exp_t exp_f = '0;
  logic exp_valid = 1'b0;
  exp_t nxt;
  assign nxt = model(instr, pc, rs1_data, rs2_data);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_f     <= '0;
    end else if (flush) begin
      exp_valid <= 1'b0;
      exp_f     <= '0;
      if (in_valid) $display("txn drop-by-flush instr=%08h", instr);
    end else if (in_valid && (!exp_valid || out_ready)) begin
      $display("txn accept instr=%08h pc=%08h rs1=%08h rs2=%08h illegal=%0d",
               instr, pc, rs1_data, rs2_data, nxt.ill);
      if (nxt.ill && !TRAP) begin
        exp_valid <= 1'b0;
        exp_f     <= '0;
      end else begin
        exp_valid <= 1'b1;
        exp_f     <= nxt;
      end
    end else if (out_ready) begin
      exp_valid <= 1'b0;
      exp_f     <= '0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", out_valid, exp_valid);
      chk("in_ready", in_ready, !exp_valid || out_ready);
      chk("alucontrol", ex_alucontrol, exp_f.alu);
      chk("regwrite", ex_regwrite, exp_f.rw);
      chk("memread", ex_memread, exp_f.mr);
      chk("memwrite", ex_memwrite, exp_f.mw);
      chk("branch", ex_branch, exp_f.br);
      chk("branch_ne", ex_branch_ne, exp_f.bne);
      chk("illegal", ex_illegal, exp_f.ill);
      if (exp_valid && !exp_f.ill) begin
        chk("a", ex_a, exp_f.a);
        chk("b", ex_b, exp_f.b);
        chk("store_data", ex_store_data, exp_f.sd);
        chk("imm", ex_imm, exp_f.imm);
        chk("rd", ex_rd, exp_f.rd);
      end
    end
  end

  task automatic send(input logic [31:0] ins, pcv, r1, r2);
    instr = ins; pc = pcv; rs1_data = r1; rs2_data = r2;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst alucontrol", ex_alucontrol, 0);
    chk("rst in_ready", in_ready, 1);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // SUB x3,x1,x2
    send(32'h402081B3, 32'h0, 32'd10, 32'd3);
    chk("sub valid", out_valid, 1);
    chk("sub alu", ex_alucontrol, 4'b0110);
    chk("sub a", ex_a, 10);
    chk("sub b", ex_b, 3);
    chk("sub rd", ex_rd, 3);
    chk("sub regwrite", ex_regwrite, 1);

    // SRAI x5,x6,3
    send(32'h40335293, 32'h4, 32'h8000_0000, 32'h0);
    chk("srai alu", ex_alucontrol, 4'b0100);
    chk("srai b", ex_b, 3);

    // SLL x1,x2,x3 with a shift register value above 31
    send(32'h003110B3, 32'h8, 32'h1, 32'h25);
    chk("sll alu", ex_alucontrol, 4'b0001);
    chk("sll b", ex_b, 5);

    // SLT x1,x2,x3
    send(32'h003120B3, 32'hC, 32'h1, 32'h2);
`ifdef ALUDEC_ILLEGAL_TRAP_EN
    chk("slt valid", out_valid, 1);
    chk("slt illegal", ex_illegal, 1);
    chk("slt regwrite", ex_regwrite, 0);
    chk("slt alu", ex_alucontrol, 4'b0010);
`else
    chk("slt bubble", out_valid, 0);
    chk("slt illegal", ex_illegal, 0);
`endif

    // LUI x7,0x12345
    send(32'h123453B7, 32'h10, 32'hDEAD_BEEF, 32'h0);
    chk("lui alu", ex_alucontrol, 4'b0010);
    chk("lui a", ex_a, 0);
    chk("lui b", ex_b, 32'h1234_5000);

    // ADDI x0,x0,0
    send(32'h00000013, 32'h14, 32'h0, 32'h0);
    chk("nop regwrite", ex_regwrite, 0);

    // SW x5,8(x2)
    send(32'h00512423, 32'h18, 32'h1000, 32'hCAFE);
    chk("sw b", ex_b, 8);
    chk("sw memwrite", ex_memwrite, 1);
    chk("sw store_data", ex_store_data, 32'hCAFE);
    chk("sw regwrite", ex_regwrite, 0);

    // LW x4,-4(x1)
    send(32'hFFC0A203, 32'h1C, 32'h2000, 32'h0);
    chk("lw b", ex_b, 32'hFFFF_FFFC);
    chk("lw memread", ex_memread, 1);

    // BNE x1,x2,+16
    send(32'h00209863, 32'h20, 32'h5, 32'h6);
    chk("bne imm", ex_imm, 16);
    chk("bne branch_ne", ex_branch_ne, 1);
    chk("bne regwrite", ex_regwrite, 0);

    // JAL x1,+8 and AUIPC x2,1
    send(32'h008000EF, 32'h24, 32'h0, 32'h0);
    chk("jal a", ex_a, 32'h24);
    chk("jal b", ex_b, 4);
    chk("jal imm", ex_imm, 8);
    send(32'h00001117, 32'h28, 32'h0, 32'h0);
    chk("auipc b", ex_b, 32'h1000);

    // BLT and an unknown opcode: both illegal
    send(32'h0020C463, 32'h2C, 32'h1, 32'h2);
    chk("blt branch", ex_branch, 0);
    send(32'hFFFFFFFF, 32'h30, 32'h1, 32'h2);
    chk("unknown memread", ex_memread, 0);

    // Back-pressure: hold ADD while ANDI waits upstream.
    send(32'h002081B3, 32'h100, 32'd7, 32'd9);
    out_ready = 1'b0;
    instr = 32'hFFF3F313; pc = 32'h104; rs1_data = 32'h55; rs2_data = 32'h0;
    in_valid = 1'b1;
    #1;
    chk("stall in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall valid", out_valid, 1);
      chk("stall a", ex_a, 7);
      chk("stall b", ex_b, 9);
      chk("stall in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release valid", out_valid, 1);
    chk("release alu", ex_alucontrol, 4'b0011);
    chk("release a", ex_a, 32'h55);
    chk("release b", ex_b, 32'hFFFF_FFFF);

    // Flush with a held op and a new incoming op.
    instr = 32'h123453B7;
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush valid", out_valid, 0);
    chk("flush regwrite", ex_regwrite, 0);
    flush = 1'b0;
    in_valid = 1'b0;

    // Reset asserted in the middle of a stall.
    send(32'h402081B3, 32'h200, 32'd10, 32'd3);
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("prerst valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst valid", out_valid, 0);
    chk("midrst alu", ex_alucontrol, 0);
    chk("midrst a", ex_a, 0);
    chk("midrst b", ex_b, 0);
    chk("midrst rd", ex_rd, 0);
    chk("midrst regwrite", ex_regwrite, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    send(32'h402081B3, 32'h300, 32'd1, 32'd1);
    chk("postrst valid", out_valid, 1);
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_decode.md
# id_ex_alu_decode

Decode-to-execute stage of the pipelined RV32I core. It decodes a fetched instruction into the 4-bit ALU control code and the ALU operand pair consumed by the execute-stage ALU, and holds them in the ID/EX pipeline register. The register uses a valid/ready handshake and supports flush. It also flags instructions the ALU cannot execute (e.g. SLT/SLTU, BLT…), so the hazard/trap logic can react.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept (combinational)
- instr  in  32  instruction word
- pc  in  32  instruction address
- rs1_data, rs2_data  in  32 each  forwarded register operands
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  ID/EX register holds valid op
- out_ready  in  1  execute stage consumes this cycle
- ex_alucontrol  out  4  ALU code
- ex_a, ex_b  out  32 each  ALU operands
- ex_store_data  out  32  rs2_data for stores
- ex_imm  out  32  sign-extended immediate (branch/jump target use)
- ex_rd  out  5  destination register
- ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_branch_ne, ex_illegal  out  1 each

## Operation
- ALU codes (fixed): ADD 0010, SUB 0110, SLL 0001, SRL 0101, SRA 0100, XOR 0000, AND 0011, OR 1000.
- R-type (0110011), funct7=0000000: f3 000 ADD, 001 SLL, 100 XOR, 101 SRL, 110 OR, 111 AND. funct7=0100000: f3 000 SUB, 101 SRA. Any other combination is illegal. a=rs1_data. b=rs2_data, except shifts, where b={27'b0, rs2_data[4:0]}.
- I-ALU (0010011): f3 000/100/110/111 map to ADD/XOR/OR/AND with b=sign-ext imm. Shifts use b={27'b0, instr[24:20]}:
  - SLLI/SRLI require instr[31:25]=0000000.
  - SRAI requires 0100000.
  - f3 010/011 are illegal.
- Load (0000011): ADD, b=I-imm, memread=1.
- Store (0100011): ADD, b=S-imm, memwrite=1, regwrite=0.
- Branch (1100011): SUB, a=rs1, b=rs2, ex_imm=B-imm, branch=1.
  - f3 000 gives branch_ne=0; f3 001 gives branch_ne=1.
  - All other f3 values are illegal.
- LUI: ADD, a=0, b=U-imm. AUIPC: ADD, a=pc, b=U-imm.
- JAL/JALR: ADD, a=pc, b=4 (link), ex_imm = J-imm / I-imm.
- Unknown opcode: illegal.
- regwrite is forced to 0 when rd=0, and also for store, branch and illegal instructions.
- Illegal instructions always get memread=memwrite=branch=0.

## Timing
- Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
- in_ready = !out_valid || out_ready.
- While out_valid && !out_ready, all ex_* outputs hold stable.
- flush: on the next edge out_valid=0 and any incoming instruction is dropped. Flush has priority over accept and over hold.
- Accept and consume in the same cycle: the register loads the new op and out_valid stays 1.
- Reset (async assert, sync release): out_valid=0 and every ex_* output = 0 (alucontrol 0000). Asserting reset mid-stall discards the held op.
- Control fields are 0 whenever out_valid=0 (bubble); operand fields are don't-care.

## Configuration
- ALUDEC_ILLEGAL_TRAP_EN defined:
  - an illegal decode loads with out_valid=1 and ex_illegal=1;
  - alucontrol=0010, all side effects off.
- Undefined:
  - ex_illegal is tied 0;
  - an illegal instruction is accepted but loaded as a bubble (out_valid=0).

## Structure
- Shared package alu_pkg holds:
  - ALU code localparams (ALU_ADD…ALU_OR) and opcode constants;
  - an alu_op_t 4-bit typedef, shared with the ALU.
- One sub-module: alu_dec_comb, a purely combinational decode of instr/pc/operands into the next-state fields. The top holds only the handshake and register.

## Test plan
- SUB x3,x1,x2 (0x402081B3), rs1=10, rs2=3, out_ready=1 → next cycle out_valid=1, alucontrol=0110, a=10, b=3, rd=3, regwrite=1.
- SRAI x5,x6,3 (0x40335293), rs1=0x80000000 → alucontrol=0100, b=3. R-type SLL with rs2_data=0x25 → b=5.
- SLT x1,x2,x3 (0x003120B3):
  - with macro → ex_illegal=1, regwrite=0;
  - without macro → out_valid=0.
- LUI x7,0x12345 (0x123453B7) → a=0, b=0x12345000, ADD. ADDI x0,x0,0 (0x00000013) → regwrite=0.
- Hold out_ready=0 for 3 cycles with new instr presented → in_ready=0 and outputs unchanged. Release → next op loads on the same edge the old one is consumed.
- Cycle A: flush with out_valid=1 and in_valid=1 → out_valid=0. Cycle B: assert rst_n=0 mid-stall → all outputs 0 immediately.
